// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port byte memory between the CPU (port 0)
// and the debug/loader port (port 1), with starvation protection and range checking.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_AW       = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [15:0]       addr0,
  input  logic [15:0]       addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [7:0]        rdata0,
  output logic [7:0]        rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  wait1;
  logic        starve;
  logic        any_gnt;
  logic        win_we;
  logic        in_range;
  logic [15:0] win_addr;
  logic [7:0]  win_wdata;
  logic        rvalid0_q;
  logic        rvalid1_q;
  logic        err0_q;
  logic        err1_q;
  logic [7:0]  hold0;
  logic [7:0]  hold1;

  always_comb begin
    starve    = req1 && (wait1 == LIMIT);
    gnt1      = !reset && req1 && (starve || !req0);
    gnt0      = !reset && req0 && !starve;
    any_gnt   = gnt0 || gnt1;
    win_we    = gnt1 ? we1 : we0;
    win_addr  = gnt1 ? addr1 : addr0;
    win_wdata = gnt1 ? wdata1 : wdata0;
    in_range  = (win_addr[15:MEM_AW] == '0);
    mem_en    = any_gnt && in_range;
    mem_we    = mem_en && win_we;
    mem_addr  = win_addr[MEM_AW-1:0];
    mem_wdata = win_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait1     <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      hold0     <= 8'h00;
      hold1     <= 8'h00;
      cnt0      <= 16'd0;
      cnt1      <= 16'd0;
    end else begin
      if (!req1 || gnt1)
        wait1 <= 4'd0;
      else if (wait1 < LIMIT)
        wait1 <= wait1 + 4'd1;

      rvalid0_q <= gnt0 && !we0;
      rvalid1_q <= gnt1 && !we1;
      err0_q    <= gnt0 && !in_range;
      err1_q    <= gnt1 && !in_range;

      // A fresh out-of-range read outranks capturing the read data now on the bus.
      if (gnt0 && !we0 && !in_range)
        hold0 <= 8'hFF;
      else if (rvalid0_q && !err0_q)
        hold0 <= mem_rdata;

      if (gnt1 && !we1 && !in_range)
        hold1 <= 8'hFF;
      else if (rvalid1_q && !err1_q)
        hold1 <= mem_rdata;

      if (gnt0)
        cnt0 <= cnt0 + 16'd1;
      if (gnt1)
        cnt1 <= cnt1 + 16'd1;
    end
  end

  // Responses already in flight are suppressed while reset is held.
  assign rvalid0 = rvalid0_q && !reset;
  assign rvalid1 = rvalid1_q && !reset;
  assign err0    = err0_q && !reset;
  assign err1    = err1_q && !reset;
  assign rdata0  = (rvalid0_q && !err0_q) ? mem_rdata : hold0;
  assign rdata1  = (rvalid1_q && !err1_q) ? mem_rdata : hold1;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter in front of the 512-byte single-port program/data memory. It shares that memory between the CPU core's load/fetch path (port 0) and the debug/loader port (port 1). Port 0 normally wins; port 1 is protected from starvation by a programmable wait limit. Out-of-range addresses are answered with an error instead of a memory access, and the block keeps per-port access counters for debug.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive blocked cycles after which a waiting port 1 wins over port 0. Legal range 1..15.
- `MEM_AW`, default 9: memory address width. Memory depth is 2^MEM_AW bytes.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  access request, port 0 (CPU) and port 1 (debug).
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  16  `addr_t` byte address.
- `wdata0`, `wdata1`  in  8  `data_t` write data.
- `gnt0`, `gnt1`  out  1  request accepted this cycle (combinational).
- `rvalid0`, `rvalid1`  out  1  read data valid (registered).
- `rdata0`, `rdata1`  out  8  read data. Valid only while the matching `rvalid` is 1.
- `err0`, `err1`  out  1  out-of-range access, registered. Asserted together with `rvalid` or the write-completion cycle.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  MEM_AW  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data, registered inside the memory, 1-cycle latency.
- `cnt0`, `cnt1`  out  16  accepted-access counters, wrap at 0xFFFF to 0.

## Operation
- At most one access is granted per cycle. Winner selection:
  - Port 1 wins if `req1` and `wait1 == STARVE_LIMIT`.
  - Otherwise port 0 wins if `req0`.
  - Otherwise port 1 wins if `req1`.
- `wait1` is a 4-bit counter:
  - Increments, saturating at `STARVE_LIMIT`, on each cycle with `req1 & !gnt1`.
  - Clears to 0 on `gnt1` or when `req1` = 0.
- Handshake rules:
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - `gnt` is a single-cycle acceptance. If the requester still has `req` high on the next cycle, that is a new access.
- In-range grant (`addr[15:MEM_AW]` = 0):
  - `mem_en` = 1, `mem_we` = winner's `we`, `mem_addr` = `addr[MEM_AW-1:0]`, `mem_wdata` = winner's `wdata`.
  - All memory outputs come from the winner's inputs in the same cycle.
- Out-of-range grant:
  - `mem_en` = 0 and memory contents are untouched.
  - Next cycle `err` = 1 for that port. A read also returns `rdata` = 0xFF with `rvalid` = 1.
- When nothing is granted, `mem_en` = 0 and `mem_we` = 0. `mem_addr` and `mem_wdata` are don't-care.
- A read grant schedules `rvalid` for the granted port on the next cycle. The `rdata` for that port is `mem_rdata` (or 0xFF if out of range).
- `rdata` holds its last value while `rvalid` = 0.
- A write grant produces no `rvalid`. `err` may still pulse for it.
- `cntN` increments by 1 on every `gntN`, for both reads and writes, in range or not.

## Timing
- Reset values, applied on the first rising edge with `reset` = 1:
  - `wait1` = 0, `rvalid0/1` = 0, `err0/1` = 0, `rdata0/1` = 0x00, `cnt0/1` = 0.
- While `reset` = 1: `gnt0/1` = 0, `mem_en` = 0, `mem_we` = 0.
- Reset in the middle of an access: a read granted in the cycle before reset is dropped, and no `rvalid` appears after reset.
- Latencies:
  - Grant: 0 cycles from `req`, combinational.
  - Read data: `rvalid` exactly 1 cycle after `gnt`.
  - Write: the memory is updated at the edge that ends the grant cycle.
- Back-to-back grants to the same port are allowed, one per cycle. `rvalid` then stays high for consecutive cycles, with new data each cycle.
- A read grant to one port followed by a grant to the other port in the next cycle is legal. The two `rvalid` signals then pulse in consecutive cycles on their own ports.
- Same-address write then read is covered by the memory's own write-first behaviour. No forwarding in this block.
- Sustained contention with both requests held high: the grant pattern is `STARVE_LIMIT` grants to port 0, then 1 grant to port 1, repeating.

## Test plan
- Reset, then idle with `req0 = req1 = 0` for 5 cycles → all outputs at reset values, `mem_en` = 0 throughout.
- `req0` read at 0x0003 with memory[3] = 0xA2 → `gnt0` in cycle 0; `rvalid0` = 1 and `rdata0` = 0xA2 in cycle 1; `cnt0` = 1.
- `req1` write 0x5C to 0x01FF, then `req0` read at 0x01FF → `mem_we` = 1 with `mem_addr` = 0x1FF on the write; the read returns 0x5C; `cnt1` = 1.
- `STARVE_LIMIT` = 3, both ports requesting continuously for 8 cycles → grants 0,0,0,1,0,0,0,1; `cnt0` = 6, `cnt1` = 2.
- `req0` read at 0x0200 → `gnt0` with `mem_en` = 0; next cycle `rvalid0` = 1, `err0` = 1, `rdata0` = 0xFF.
- Read granted in cycle N, `reset` high in cycle N+1 → `rvalid0` stays 0; `cnt0` = 0 after reset.
